// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control block: the opcode
// constants, the state encoding, the ALU/PC mux encodings and the control
// word that the decoder hands back to the top level.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-word decoder.
//   state_i     : current FSM state
//   mem_ready_i : memory handshake, only consulted in FETCH
//   ctrl_o      : datapath strobes and mux selects for this cycle
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                // IR and PC only latch once the fetch has actually completed
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_SEXT_SH2;
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
//   clk_i, rst_ni       : clock, async active-low reset
//   opcode_i, zero_i    : instruction opcode, ALU zero flag
//   mem_ready_i         : memory completed the current access
//   *_o strobes/selects : datapath control (zero while in reset)
//   illegal_o           : pulse in DECODE for an unsupported opcode
//   state_o             : current state, for debug
//   instr_count_o       : retired instruction count (wraps)
// zero_i is carried for interface completeness; branch gating on it is
// done in the datapath.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        mem_to_reg_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  pc_source_o,
    output logic        illegal_o,
    output logic [3:0]  state_o,
    output logic [31:0] instr_count_o
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        retire;
    ctrl_t       ctrl_raw, ctrl;

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl_raw)
    );

    // Reset is sampled directly so no strobe can fire while it is held low
    assign ctrl = rst_ni ? ctrl_raw : '0;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:   state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:   retire  = 1'b1;
            S_MEMWR: begin
                state_d = mem_ready_i ? S_FETCH : S_MEMWR;
                retire  = mem_ready_i;
            end
            S_EXEC:    state_d = S_RTYPEWB;
            S_RTYPEWB: retire  = 1'b1;
            S_BRANCH:  retire  = 1'b1;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  retire  = 1'b1;
            S_JUMP:    retire  = 1'b1;
            default:   state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign iord_o          = ctrl.iord;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_write_o     = ctrl.reg_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign pc_source_o     = ctrl.pc_source;
    assign illegal_o       = rst_ni && (state_q == S_DECODE) && !is_supported(opcode_i);
    assign state_o         = state_q;
    assign instr_count_o   = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_write, reg_dst, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;

    mips_multicycle_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
        .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .reg_dst_o(reg_dst), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .pc_source_o(pc_source), .illegal_o(illegal),
        .state_o(state), .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [31:0] cnt;
        logic [16:0] w;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 0;

    // Expected control word per state, straight from the state table.
    // Order: pcw pcwc iord mrd mwr irw m2r rw rdst srca srcb aluop pcsrc illegal
    function automatic logic [16:0] model_w(int st, bit mr, bit ill);
        bit pcw = 0, pcwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        bit rw = 0, rd = 0, sa = 0;
        bit [1:0] sbx = 0, ao = 0, ps = 0;
        case (st)
            0:  begin mrd = 1; sbx = 2'b01; irw = mr; pcw = mr; end
            1:  sbx = 2'b11;
            2:  begin sa = 1; sbx = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
            9:  begin sa = 1; sbx = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa, sbx, ao, ps, ill};
    endfunction

    // One clock cycle of stimulus plus its expected response
    task automatic cyc(bit rst, bit [5:0] op, bit mr, int st, bit ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        opcode = op;
        mem_ready = mr;
        zero = 1'($urandom);
        if (!rst) model_cnt = 0;
        e.st  = rst ? st : 0;
        e.cnt = model_cnt;
        e.w   = rst ? model_w(st, mr, ill) : 17'd0;
        sb_q.push_back(e);
    endtask

    // Runs one instruction through the model. fstall/mstall: number of
    // not-ready cycles in FETCH / memory states, -1 picks one at random.
    // abort pulls reset after the first MEMRD cycle.
    task automatic run_instr(bit [5:0] op, int fstall, int mstall, bit abort);
        int  path[$];
        bit  ill = 0;
        int  n;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            default: begin path = '{0, 1}; ill = 1; end
        endcase
        foreach (path[k]) begin
            if (path[k] == 0 || path[k] == 3 || path[k] == 5) begin
                if (abort && path[k] == 3) begin
                    cyc(1, op, 0, 3, 0);
                    cyc(0, op, 1, 0, 0);
                    cyc(0, op, 1, 0, 0);
                    return;
                end
                n = (path[k] == 0) ? fstall : mstall;
                if (n < 0) n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) cyc(1, op, 0, path[k], 0);
                cyc(1, op, 1, path[k], 0);
            end else begin
                cyc(1, op, 1'($urandom), path[k], (path[k] == 1) && ill);
            end
        end
        if (!ill) model_cnt = model_cnt + 1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (state !== mon_e.st[3:0] || instr_count !== mon_e.cnt ||
                {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal} !== mon_e.w) begin
                errors++;
                $display("FAIL cycle@%0t state got %0d want %0d count got %0d want %0d ctrl got %h want %h",
                         $time, state, mon_e.st, instr_count, mon_e.cnt,
                         {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                          reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal},
                         mon_e.w);
            end
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL memrw_excl got rd=%0b wr=%0b want not both", mem_read, mem_write);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit [5:0] ops[7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        // reset held, then directed cases
        cyc(0, 6'd0, 1, 0, 0);
        cyc(0, 6'd0, 1, 0, 0);
        run_instr(6'b100011, 0, 0, 0);   // lw, no stalls
        run_instr(6'b101011, 0, 3, 0);   // sw, 3 stalls in MEMWR
        run_instr(6'b000100, 0, 0, 0);   // beq
        run_instr(6'b000010, 0, 0, 0);   // j
        run_instr(6'b111111, 0, 0, 0);   // illegal
        run_instr(6'b000000, 2, 0, 0);   // R-type with fetch stall
        run_instr(6'b001000, 0, 0, 0);   // addi
        run_instr(6'b100011, 1, 2, 0);   // lw with stalls
        run_instr(6'b100011, 0, 2, 1);   // lw aborted by reset in MEMRD
        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 6)], -1, -1, 0);
        run_instr(6'b100011, 0, 1, 1);   // another abort, after a random run
        run_instr(6'b000010, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control state machine for the multicycle MIPS datapath. It replaces the single-cycle combinational control unit and sequences one shared memory, the instruction register, the register file, the ALU and the PC. Each instruction executes over 3–5 states, plus extra cycles whenever memory stalls. Every datapath strobe and mux select comes from this block, and it counts retired instructions.

## Interface
- No parameters.
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-low reset.
- OpCode  in  6  Instruction[31:26], taken from the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath strobes and mux selects.
- ALUSrcB  out  2  ALU B-input select: 00 = regB, 01 = constant 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct field.
- PCSource  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- Illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- State  out  4  current state encoding, for debug.
- InstrCount  out  32  number of retired instructions.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Outputs are Moore-decoded from the state. The only exceptions are the FETCH strobes noted below. Unlisted outputs are 0.
- FETCH (0): MemRead=1, ALUSrcB=01.
  - IRWrite = PCWrite = MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE (1): ALUSrcB=11, computes the branch target. Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → pulse Illegal and return to FETCH. The instruction is not counted.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10. Next: lw → MEMRD, sw → MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Hold until MemReady=1, then → MEMWB.
- MEMWB (4): RegWrite=1, MemToReg=1, RegDst=0. → FETCH, retire.
- MEMWR (5): MemWrite=1, IorD=1. Hold until MemReady=1, then → FETCH, retire.
- EXEC (6): ALUSrcA=1, ALUOp=10. → RTYPEWB.
- RTYPEWB (7): RegWrite=1, RegDst=1. → FETCH, retire.
- BRANCH (8): ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH, retire.
  - The effective PC write is PCWrite | (PCWriteCond & Zero); this gating happens in the datapath, not here.
- ADDIEX (9): ALUSrcA=1, ALUSrcB=10. → ADDIWB.
- ADDIWB (10): RegWrite=1, RegDst=0. → FETCH, retire.
- JUMP (11): PCWrite=1, PCSource=10. → FETCH, retire.
- Encodings 12–15 are unreachable. If ever entered, the next state is FETCH with all outputs 0.
- Retire: InstrCount increments by 1 on the clock edge that leaves a retiring state. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset low: state = FETCH and InstrCount = 0, applied asynchronously. While Reset is low, every strobe is forced to 0.
- Reset release: the first FETCH read starts on the first edge after Reset goes high.
- Latency with MemReady tied high:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle that MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- MemRead and MemWrite are held stable for the whole stall, and are never asserted together.
- MemReady is ignored in every state except FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: abort at once. No further writes occur, and the count is not incremented.
- State and InstrCount are registered. All other outputs are combinational from State (plus MemReady in FETCH).

## Structure
- Package mips_ctrl_pkg holds:
  - the opcode constants;
  - a 4-bit state enum/localparams with the encodings above;
  - the ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mips_ctrl_decode: purely combinational, mapping (State, MemReady) to the control word.
- The top level holds the state register, next-state logic and InstrCount.

## Test plan
- Reset low, then release, with MemReady=1 → State 0 → 1. IRWrite=PCWrite=1 in the first cycle. InstrCount=0.
- lw (OpCode 100011), MemReady=1 → States 0, 1, 2, 3, 4, 0. RegWrite=MemToReg=1 only in state 4. InstrCount 0 → 1.
- sw with MemReady held low for 3 cycles in MEMWR → State stays 5 for 4 cycles with MemWrite=1 and IorD=1 throughout. Then FETCH, and the count increments once.
- beq → BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01. j → JUMP shows PCWrite=1, PCSource=10. Each takes 3 cycles.
- OpCode 111111 → Illegal pulses for one cycle in DECODE, next state FETCH, InstrCount unchanged.
- Reset pulled low during MEMRD → State=0 and InstrCount=0 immediately, before the next clock edge, with all strobes 0.
